// File: rtl/axilite_write_ctrl.sv
// AXI-Lite write-channel controller: captures AW/W, issues one register-file write, returns a response.
// Optional macro AXILITE_WSTRB_EN forwards wstrb and skips writes whose captured strobe is all zero.
module axilite_write_ctrl #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_ack,
    input  logic                wr_err,
    output logic [1:0]          resp,
    output logic                resp_valid,
    input  logic                b_done
);

    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HAVE_AW,
        S_HAVE_W,
        S_WRITE,
        S_WAIT_ACK,
        S_RESP,
        S_WAIT_B
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_awready;
    logic              r_wready;
    logic              r_wr_en;
    logic              r_resp_valid;
    logic [1:0]        r_resp;
    logic [1:0]        w_resp_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_cap;
    logic [DATA_W-1:0] r_data;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_strb_zero_cap;
    logic              w_do_write;

    assign w_aw_hs    = awvalid & r_awready;
    assign w_w_hs     = wvalid & r_wready;
    assign w_addr_cap = w_aw_hs ? awaddr : r_addr;

`ifdef AXILITE_WSTRB_EN
    logic [STRB_W-1:0] r_strb;

    assign w_strb_zero_cap = ((w_w_hs ? wstrb : r_strb) == '0);
    assign wr_strb         = r_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strb <= '0;
        end else if (w_w_hs) begin
            r_strb <= wstrb;
        end
    end
`else
    logic w_unused_strb;

    assign w_unused_strb   = ^wstrb;
    assign w_strb_zero_cap = 1'b0;
    assign wr_strb         = {STRB_W{r_wr_en}};
`endif

    // Qualify the write from the values being captured so wr_en can be registered on entry to WRITE.
    assign w_do_write = (w_addr_cap < ADDR_LIMIT) && !w_strb_zero_cap;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_resp_nxt  = r_resp;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_state_nxt = S_WRITE;
                end else if (w_aw_hs) begin
                    w_state_nxt = S_HAVE_AW;
                end else if (w_w_hs) begin
                    w_state_nxt = S_HAVE_W;
                end
            end
            S_HAVE_AW: if (w_w_hs)  w_state_nxt = S_WRITE;
            S_HAVE_W:  if (w_aw_hs) w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (!r_wr_en) begin
                    w_state_nxt = S_RESP;
                    w_resp_nxt  = (r_addr >= ADDR_LIMIT) ? RESP_SLVERR : RESP_OKAY;
                end else if (wr_ack) begin
                    w_state_nxt = S_RESP;
                    w_resp_nxt  = wr_err ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (wr_ack) begin
                    w_state_nxt = S_RESP;
                    w_resp_nxt  = wr_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            S_RESP:   w_state_nxt = S_WAIT_B;
            S_WAIT_B: if (b_done) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp       <= RESP_OKAY;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_awready    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HAVE_W);
            r_wready     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HAVE_AW);
            r_wr_en      <= (w_state_nxt == S_WRITE) && w_do_write;
            r_resp_valid <= (w_state_nxt == S_RESP);
            r_resp       <= w_resp_nxt;
            if (w_aw_hs) r_addr <= awaddr;
            if (w_w_hs)  r_data <= wdata;
        end
    end

    assign awready    = r_awready;
    assign wready     = r_wready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = r_data;
    assign resp       = r_resp;
    assign resp_valid = r_resp_valid;

endmodule

// File: tb/tb_axilite_write_ctrl.sv
// Scoreboard bench for axilite_write_ctrl: expected writes and responses are queued at stimulus time
// and popped when the DUT raises wr_en / resp_valid.
module tb_axilite_write_ctrl;

    localparam int unsigned       ADDR_W = 32;
    localparam int unsigned       DATA_W = 32;
    localparam int unsigned       STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LIMIT  = 32'h0000_1000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_ack;
    logic              wr_err;
    logic [1:0]        resp;
    logic              resp_valid;
    logic              b_done;

    wr_t        wq[$];
    logic [1:0] rq[$];
    wr_t        mon_w;
    logic [1:0] mon_r;
    int n_tests   = 0;
    int n_fail    = 0;
    int wr_en_cnt = 0;
    int resp_cnt  = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;

    always #5 clk = ~clk;

    axilite_write_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ADDR_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .resp      (resp),
        .resp_valid(resp_valid),
        .b_done    (b_done)
    );

    // Scoreboard monitor, sampling on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (awvalid && awready) aw_hs_cnt++;
            if (wvalid && wready)   w_hs_cnt++;
            if (wr_en === 1'b1) begin
                wr_en_cnt++;
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_req_unexpected: got wr_en addr=%h data=%h, required no write", wr_addr, wr_data);
                end else begin
                    mon_w = wq.pop_front();
                    if ({wr_addr, wr_data, wr_strb} !== mon_w) begin
                        n_fail++;
                        $display("FAIL wr_req: got addr=%h data=%h strb=%b, required addr=%h data=%h strb=%b",
                                 wr_addr, wr_data, wr_strb, mon_w.addr, mon_w.data, mon_w.strb);
                    end
                end
            end
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                n_tests++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_unexpected: got resp_valid with resp=%b, required none", resp);
                end else begin
                    mon_r = rq.pop_front();
                    if (resp !== mon_r) begin
                        n_fail++;
                        $display("FAIL resp_value: got %b, required %b", resp, mon_r);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input logic err, output bit exp_write);
        wr_t e;
        bit  oor;
        bit  zero;
        oor    = (addr >= LIMIT);
        e.addr = addr;
        e.data = data;
`ifdef AXILITE_WSTRB_EN
        zero   = (strb == 4'b0000);
        e.strb = strb;
`else
        zero   = 1'b0;
        e.strb = 4'b1111;
`endif
        exp_write = !oor && !zero;
        if (exp_write) wq.push_back(e);
        if (oor)            rq.push_back(2'b10);
        else if (!exp_write) rq.push_back(2'b00);
        else                rq.push_back(err ? 2'b10 : 2'b00);
    endtask

    task automatic drive_both(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
    endtask

    task automatic wait_resp();
        int i;
        i = 0;
        while (resp_valid !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        n_tests++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, i);
        end
    endtask

    // Valids must already be driven; the next edge completes the capture.
    task automatic finish_txn(input bit exp_write, input logic [31:0] addr, input logic [31:0] data,
                              input int ack_delay, input logic err);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n_tests++;
        if (wr_en !== exp_write) begin
            n_fail++;
            $display("FAIL wr_en_after_capture: got %b, required %b", wr_en, exp_write);
        end
        if (exp_write) begin
            for (int d = 0; d < ack_delay; d++) tick();
            if (ack_delay > 0) begin
                n_tests++;
                if (wr_en !== 1'b0 || wr_addr !== addr || wr_data !== data) begin
                    n_fail++;
                    $display("FAIL wr_hold: got wr_en=%b addr=%h data=%h, required 0 %h %h",
                             wr_en, wr_addr, wr_data, addr, data);
                end
            end
            wr_ack = 1'b1;
            wr_err = err;
            tick();
            wr_ack = 1'b0;
            wr_err = 1'b0;
        end
        wait_resp();
    endtask

    task automatic do_b_done();
        tick();
        n_tests++;
        if (awready !== 1'b0 || wready !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_b: got awready=%b wready=%b resp_valid=%b, required 0 0 0",
                     awready, wready, resp_valid);
        end
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        n_tests++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got awready=%b wready=%b, required 1 1", awready, wready);
        end
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int ack_delay, input logic err);
        bit ew;
        int wr0;
        int rs0;
        wr0 = wr_en_cnt;
        rs0 = resp_cnt;
        push_expect(addr, data, strb, err, ew);
        drive_both(addr, data, strb);
        finish_txn(ew, addr, data, ack_delay, err);
        do_b_done();
        n_tests++;
        if ((wr_en_cnt - wr0) != (ew ? 1 : 0) || (resp_cnt - rs0) != 1) begin
            n_fail++;
            $display("FAIL txn_counts addr=%h: got wr_en=%0d resp=%0d, required %0d 1",
                     addr, wr_en_cnt - wr0, resp_cnt - rs0, ew ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        wr_ack  = 1'b0;
        wr_err  = 1'b0;
        b_done  = 1'b0;
        #22;
        n_tests++;
        if ({awready, wready, wr_en, resp_valid, resp} !== 6'b0 || wr_addr !== '0 || wr_data !== '0 || wr_strb !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got awready=%b wready=%b wr_en=%b resp_valid=%b resp=%b addr=%h, required all 0",
                     awready, wready, wr_en, resp_valid, resp, wr_addr);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got awready=%b wready=%b, required 1 1", awready, wready);
        end
    endtask

    task automatic test_same_cycle();
        run_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0);
    endtask

    task automatic test_w_before_aw();
        bit ew;
        int aw0;
        int w0;
        int wr0;
        aw0 = aw_hs_cnt;
        w0  = w_hs_cnt;
        wr0 = wr_en_cnt;
        push_expect(32'h0000_0024, 32'hCAFE_F00D, 4'hF, 1'b0, ew);
        wdata  = 32'hCAFE_F00D;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        n_tests++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL have_w_ready: got wready=%b awready=%b, required 0 1", wready, awready);
        end
        wdata = 32'hBAD0_BAD0;
        repeat (2) tick();
        awaddr  = 32'h0000_0024;
        awvalid = 1'b1;
        finish_txn(ew, 32'h0000_0024, 32'hCAFE_F00D, 0, 1'b0);
        do_b_done();
        n_tests++;
        if ((aw_hs_cnt - aw0) != 1 || (w_hs_cnt - w0) != 1 || (wr_en_cnt - wr0) != 1) begin
            n_fail++;
            $display("FAIL w_before_aw_counts: got aw_hs=%0d w_hs=%0d wr_en=%0d, required 1 1 1",
                     aw_hs_cnt - aw0, w_hs_cnt - w0, wr_en_cnt - wr0);
        end
    endtask

    task automatic test_addr_limit();
        run_txn(32'h0000_1000, 32'h1111_1111, 4'hF, 0, 1'b0);
        run_txn(32'h0000_0FFC, 32'h2222_2222, 4'hF, 0, 1'b0);
        run_txn(32'hFFFF_FFFC, 32'h3333_3333, 4'hF, 0, 1'b0);
    endtask

    task automatic test_err_holdoff();
        bit ew;
        bit ew2;
        int aw0;
        push_expect(32'h0000_0040, 32'h0BAD_F00D, 4'hF, 1'b1, ew);
        drive_both(32'h0000_0040, 32'h0BAD_F00D, 4'hF);
        finish_txn(ew, 32'h0000_0040, 32'h0BAD_F00D, 5, 1'b1);
        push_expect(32'h0000_0044, 32'h00C0_FFEE, 4'hF, 1'b0, ew2);
        drive_both(32'h0000_0044, 32'h00C0_FFEE, 4'hF);
        aw0 = aw_hs_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (awready !== 1'b0 || wready !== 1'b0 || resp !== 2'b10) begin
                n_fail++;
                $display("FAIL holdoff cycle %0d: got awready=%b wready=%b resp=%b, required 0 0 10",
                         i, awready, wready, resp);
            end
        end
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        n_tests++;
        if (aw_hs_cnt != aw0 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL holdoff_release: got aw_hs=%0d awready=%b, required %0d 1", aw_hs_cnt, awready, aw0);
        end
        finish_txn(ew2, 32'h0000_0044, 32'h00C0_FFEE, 0, 1'b0);
        do_b_done();
    endtask

    task automatic test_reset_mid();
        wr_t e;
        int  wr0;
        int  rs0;
        e.addr = 32'h0000_0080;
        e.data = 32'h1234_5678;
        e.strb = 4'hF;
        wq.push_back(e);
        wr0 = wr_en_cnt;
        rs0 = resp_cnt;
        drive_both(32'h0000_0080, 32'h1234_5678, 4'hF);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({awready, wready, wr_en, resp_valid} !== 4'b0 || wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got awready=%b wready=%b wr_en=%b resp_valid=%b addr=%h data=%h, required all 0",
                     awready, wready, wr_en, resp_valid, wr_addr, wr_data);
        end
        @(posedge clk);
        #4;
        rst_n  = 1'b1;
        wr_ack = 1'b1;
        tick();
        n_tests++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got awready=%b wready=%b, required 1 1", awready, wready);
        end
        repeat (3) tick();
        wr_ack = 1'b0;
        n_tests++;
        if ((resp_cnt - rs0) != 0 || (wr_en_cnt - wr0) != 1 || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_late_ack: got resp_valid=%0d wr_en=%0d resp=%b, required 0 1 00",
                     resp_cnt - rs0, wr_en_cnt - wr0, resp);
        end
    endtask

    task automatic test_wstrb();
`ifdef AXILITE_WSTRB_EN
        run_txn(32'h0000_0030, 32'hA5A5_5A5A, 4'b0000, 0, 1'b0);
        run_txn(32'h0000_0034, 32'h5A5A_A5A5, 4'b0101, 1, 1'b0);
`else
        run_txn(32'h0000_0030, 32'hA5A5_5A5A, 4'b0001, 0, 1'b0);
        run_txn(32'h0000_0034, 32'h5A5A_A5A5, 4'b0000, 1, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          dly;
        logic        err;
        for (int i = 0; i < 6; i++) begin
            a   = 32'($urandom_range(0, 1023)) << 2;
            if (i == 3) a = LIMIT + 32'h100;
            d   = $urandom;
            s   = 4'($urandom_range(1, 15));
            dly = $urandom_range(0, 3);
            err = 1'($urandom_range(0, 1));
            run_txn(a, d, s, dly, err);
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_addr_limit();
        test_err_holdoff();
        test_reset_mid();
        test_wstrb();
        test_back_to_back();
        repeat (2) tick();
        n_tests++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d writes and %0d responses pending, required 0 0",
                     wq.size(), rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
